// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - command, operand stream and mac-side signals of the mac job sequencer
interface mac_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       in_opa;
  logic [7:0]       in_opb;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       mac_opa;
  logic [7:0]       mac_opb;
  logic             mac_clr;
  logic [15:0]      mac_out;
  logic             busy;
  logic             done;
  logic [15:0]      result;
  logic             ovf;

  // master: operand source, job requester and the mac itself
  modport master (
    output start, len, in_opa, in_opb, in_valid, mac_out,
    input  in_ready, mac_opa, mac_opb, mac_clr, busy, done, result, ovf
  );

  modport slave (
    input  start, len, in_opa, in_opb, in_valid, mac_out,
    output in_ready, mac_opa, mac_opb, mac_clr, busy, done, result, ovf
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job sequencer feeding operand pairs to an 8x8->16 accumulate unit
module mac_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  mac_seq_ctrl_if.slave bus
);
  localparam int DCNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  remain;
  logic [DCNT_W-1:0] dcnt;
  logic [15:0]       prev;
  logic [7:0]        mac_opa_q;
  logic [7:0]        mac_opb_q;
  logic [15:0]       result_q;
  logic              ovf_q;
  logic              in_ready_c;
  logic              mac_clr_c;
  logic              busy_c;
  logic              done_c;
  logic              accept;
  logic              last_beat;

  assign accept    = bus.in_valid & in_ready_c;
  assign last_beat = accept && (remain == LEN_W'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    mac_clr_c  = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = (bus.len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clr_c = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready_c = (remain != '0);
        if (last_beat) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The mac has no enable: every edge without an accepted beat feeds 0*0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mac_opa_q <= '0;
      mac_opb_q <= '0;
      remain    <= '0;
      dcnt      <= '0;
      prev      <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mac_opa_q <= accept ? bus.in_opa : 8'd0;
      mac_opb_q <= accept ? bus.in_opb : 8'd0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            remain <= bus.len;
            if (bus.len == '0) begin
              result_q <= '0;
              ovf_q    <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          prev  <= '0;
          ovf_q <= 1'b0;
        end
        S_RUN: begin
          if (accept) begin
            remain <= remain - LEN_W'(1);
          end
          if (last_beat) begin
            dcnt <= DCNT_W'(MAC_LAT);
          end
          if (bus.mac_out < prev) begin
            ovf_q <= 1'b1;
          end
          prev <= bus.mac_out;
        end
        S_DRAIN: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - DCNT_W'(1);
          end else begin
            result_q <= bus.mac_out;
          end
          if (bus.mac_out < prev) begin
            ovf_q <= 1'b1;
          end
          prev <= bus.mac_out;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.mac_clr  = mac_clr_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.mac_opa  = mac_opa_q;
  assign bus.mac_opb  = mac_opb_q;
  assign bus.result   = result_q;
  assign bus.ovf      = ovf_q;
endmodule
